// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - heading encodings and helpers shared by the direction key path.
package game_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_DOWN  = 2'b01;
  localparam dir_t DIR_LEFT  = 2'b10;
  localparam dir_t DIR_RIGHT = 2'b11;

  localparam dir_t DIR_RESET = DIR_RIGHT;

  // Encodings pair up so flipping bit 0 gives the reverse heading.
  function automatic dir_t opposite(input dir_t d);
    return d ^ 2'b01;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-FF synchronizer, counter debouncer and press detector for one key.
module key_debounce #(
  parameter int DEB_CYCLES = 250000,
  parameter int CNT_W      = 18
) (
  input  logic clk,
  input  logic clr,
  input  logic key_raw,
  output logic key_level,
  output logic key_rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!clr) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      key_level <= 1'b0;
      level_d   <= 1'b0;
      cnt       <= '0;
    end else begin
      sync1   <= key_raw;
      sync2   <= sync1;
      level_d <= key_level;
      // Any return to the accepted level restarts qualification from zero.
      if (sync2 == key_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        key_level <= sync2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign key_rise = key_level & ~level_d;

endmodule

// File: rtl/dir_key_ctrl.sv
// rtl/dir_key_ctrl.sv - debounced direction keys resolved into a registered heading and strobe.
// Define REVERSE_ALLOW_EN to let a press opposite the current heading take effect.
module dir_key_ctrl
  import game_pkg::*;
#(
  parameter int DEB_CYCLES = 250000,
  parameter int CNT_W      = 18
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  output logic [1:0] dir,
  output logic       dir_pulse,
  output logic       key_any
);

  // Bit positions match the heading encodings so a heading indexes its own key.
  logic [3:0] raw;
  logic [3:0] level;
  logic [3:0] rise;
  logic [3:0] cand;
  dir_t       nxt_dir;
  logic       nxt_pulse;

  assign raw = {right, left, down, up};

  for (genvar g = 0; g < 4; g++) begin : g_key
    key_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_deb (
      .clk       (clk),
      .clr       (clr),
      .key_raw   (raw[g]),
      .key_level (level[g]),
      .key_rise  (rise[g])
    );
  end

  always_comb begin
    cand      = rise;
    cand[dir] = 1'b0;
`ifdef REVERSE_ALLOW_EN
`else
    cand[opposite(dir)] = 1'b0;
`endif
    nxt_dir   = dir;
    nxt_pulse = 1'b0;
    if (cand[DIR_UP]) begin
      nxt_dir   = DIR_UP;
      nxt_pulse = 1'b1;
    end else if (cand[DIR_DOWN]) begin
      nxt_dir   = DIR_DOWN;
      nxt_pulse = 1'b1;
    end else if (cand[DIR_LEFT]) begin
      nxt_dir   = DIR_LEFT;
      nxt_pulse = 1'b1;
    end else if (cand[DIR_RIGHT]) begin
      nxt_dir   = DIR_RIGHT;
      nxt_pulse = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      dir       <= DIR_RESET;
      dir_pulse <= 1'b0;
      key_any   <= 1'b0;
    end else begin
      dir       <= nxt_dir;
      dir_pulse <= nxt_pulse;
      key_any   <= |level;
    end
  end

endmodule
